// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller.
// Holds the FSM state type, register address map and frame field positions.
// Imported by spi_reg_ctrl; no logic lives here.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    APPLY  = 2'd2
  } state_t;

  // Register address map
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;
  localparam int MAX_ADDR       = 4;

  // Frame layout: {wr, addr[6:0], data[7:0]}
  localparam int WR_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the debug error/overrun counts.
// Latency: count reflects an inc one cycle later.
// Holds at all-ones once reached; synchronous active-high clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at all-ones so the value never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-write controller: validates 16-bit SPI frames and writes the output/PWM register bank.
// Latency: frame accepted in cycle N is visible on the register outputs in cycle N+3.
// frame_ready is high only in IDLE; a frame_valid pulse while busy is dropped and counted.
// Optional macro SPI_REG_CTRL_DUTY_SHADOW_EN: double-buffered duty committed on pwm_period_end.
module spi_reg_ctrl #(
  parameter int MAX_ADDR = spi_pkg::MAX_ADDR,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  input  logic [ADDR_W+DATA_W:0]      frame,
  output logic                        frame_ready,
  input  logic                        pwm_period_end,
  output logic [DATA_W-1:0]           en_reg_out_7_0,
  output logic [DATA_W-1:0]           en_reg_out_15_8,
  output logic [DATA_W-1:0]           en_reg_pwm_7_0,
  output logic [DATA_W-1:0]           en_reg_pwm_15_8,
  output logic [DATA_W-1:0]           pwm_duty_cycle,
  output logic                        duty_pending,
  output logic [CNT_W-1:0]            err_count,
  output logic [CNT_W-1:0]            ovr_count
);

  import spi_pkg::*;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_W+DATA_W:0]  hold_frame;
  logic [ADDR_W-1:0]       hold_addr;
  logic [DATA_W-1:0]       hold_data;
  logic                    addr_ok;
  logic                    accept;
  logic                    err_inc;
  logic                    ovr_inc;
  logic                    apply_en;

  assign hold_addr = hold_frame[ADDR_MSB:ADDR_LSB];
  assign hold_data = hold_frame[DATA_W-1:0];
  // Only writes to a mapped address are applied; reads have no path here
  assign addr_ok   = hold_frame[WR_BIT] && (int'(hold_addr) <= MAX_ADDR);
  // A pulse that arrives while a frame is in flight is lost
  assign ovr_inc   = frame_valid && !frame_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and per-state strobes
  always_comb begin
    next_state  = state;
    frame_ready = 1'b0;
    accept      = 1'b0;
    err_inc     = 1'b0;
    apply_en    = 1'b0;
    unique case (state)
      IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) begin
          accept     = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (addr_ok) begin
          next_state = APPLY;
        end else begin
          err_inc    = 1'b1;
          next_state = IDLE;
        end
      end
      APPLY: begin
        apply_en   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the accepted frame; reset discards anything held
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_frame <= '0;
    end else if (accept) begin
      hold_frame <= frame;
    end
  end

`ifdef SPI_REG_CTRL_DUTY_SHADOW_EN
  logic [DATA_W-1:0] duty_shadow;

  // Register bank: commit reads the pre-write shadow, so a same-cycle write stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      duty_shadow     <= '0;
      duty_pending    <= 1'b0;
    end else begin
      if (pwm_period_end && duty_pending) begin
        pwm_duty_cycle <= duty_shadow;
        duty_pending   <= 1'b0;
      end
      if (apply_en) begin
        case (hold_addr)
          ADDR_W'(ADDR_EN_OUT_LO): en_reg_out_7_0  <= hold_data;
          ADDR_W'(ADDR_EN_OUT_HI): en_reg_out_15_8 <= hold_data;
          ADDR_W'(ADDR_EN_PWM_LO): en_reg_pwm_7_0  <= hold_data;
          ADDR_W'(ADDR_EN_PWM_HI): en_reg_pwm_15_8 <= hold_data;
          ADDR_W'(ADDR_DUTY): begin
            duty_shadow  <= hold_data;
            duty_pending <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_pwm_period_end;
  assign unused_pwm_period_end = pwm_period_end;
  assign duty_pending          = 1'b0;

  // Register bank: duty is written directly like the other registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (apply_en) begin
      case (hold_addr)
        ADDR_W'(ADDR_EN_OUT_LO): en_reg_out_7_0  <= hold_data;
        ADDR_W'(ADDR_EN_OUT_HI): en_reg_out_15_8 <= hold_data;
        ADDR_W'(ADDR_EN_PWM_LO): en_reg_pwm_7_0  <= hold_data;
        ADDR_W'(ADDR_EN_PWM_HI): en_reg_pwm_15_8 <= hold_data;
        ADDR_W'(ADDR_DUTY):      pwm_duty_cycle  <= hold_data;
        default: ;
      endcase
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_ovr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovr_inc),
    .count (ovr_count)
  );

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a schedule-based model predicts each transaction's
// end state, a monitor compares it when frame_ready returns high.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [15:0] frame = '0;
  logic        frame_ready;
  logic        pwm_period_end = 1'b0;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic        duty_pending;
  logic [7:0]  err_count, ovr_count;

  spi_reg_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_valid     (frame_valid),
    .frame           (frame),
    .frame_ready     (frame_ready),
    .pwm_period_end  (pwm_period_end),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .duty_pending    (duty_pending),
    .err_count       (err_count),
    .ovr_count       (ovr_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  r0, r1, r2, r3, r4;
    logic        pend;
    logic [7:0]  err, ovr;
  } snap_t;

  snap_t       sbq[$];
  logic [7:0]  m_reg[5];
  logic [7:0]  m_shadow;
  logic        m_pend;
  logic [7:0]  m_err, m_ovr;
  int unsigned cyc = 0;       // index of the current cycle
  int unsigned ready_at = 0;  // first cycle in which the model accepts again
  int unsigned due_at = 0;    // cycle whose closing edge carries the write or error
  bit          job = 0;
  bit          job_ok = 0;
  logic [15:0] job_frame;
  int          m_a;

  task automatic m_clear();
    for (int i = 0; i < 5; i++) m_reg[i] = '0;
    m_shadow = '0; m_pend = 0; m_err = '0; m_ovr = '0;
  endtask

  function automatic snap_t m_snap(input int unsigned c);
    snap_t s;
    s.cyc = c; s.r0 = m_reg[0]; s.r1 = m_reg[1]; s.r2 = m_reg[2];
    s.r3 = m_reg[3]; s.r4 = m_reg[4]; s.pend = m_pend; s.err = m_err; s.ovr = m_ovr;
    return s;
  endfunction

  initial m_clear();

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      if (cyc < ready_at) sbq.push_back(m_snap(cyc + 1));
      job = 0;
      ready_at = 0;
    end else begin
`ifdef SPI_REG_CTRL_DUTY_SHADOW_EN
      if (pwm_period_end && m_pend) begin
        m_reg[4] = m_shadow;
        m_pend   = 0;
      end
`endif
      if (job && cyc == due_at) begin
        if (job_ok) begin
          m_a = int'(job_frame[14:8]);
`ifdef SPI_REG_CTRL_DUTY_SHADOW_EN
          if (m_a == 4) begin
            m_shadow = job_frame[7:0];
            m_pend   = 1;
          end else m_reg[m_a] = job_frame[7:0];
`else
          m_reg[m_a] = job_frame[7:0];
`endif
        end else if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
      if (frame_valid) begin
        if (cyc >= ready_at) begin
          job       = 1;
          job_frame = frame;
          job_ok    = frame[15] && (frame[14:8] <= 7'd4);
          due_at    = cyc + (job_ok ? 2 : 1);
          ready_at  = due_at + 1;
        end else if (m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
      end
      if (job && (cyc + 1 == ready_at)) begin
        sbq.push_back(m_snap(cyc + 1));
        job = 0;
      end
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  bit   mon_en = 0;
  logic prev_ready = 1'b1;
  snap_t s;

  always @(negedge clk) begin
    if (mon_en && frame_ready && !prev_ready) begin
      if (sbq.size() == 0) begin
        cmp("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        s = sbq.pop_front();
        cmp("done_cycle", cyc, s.cyc);
        cmp("en_out_lo", en_reg_out_7_0, s.r0);
        cmp("en_out_hi", en_reg_out_15_8, s.r1);
        cmp("en_pwm_lo", en_reg_pwm_7_0, s.r2);
        cmp("en_pwm_hi", en_reg_pwm_15_8, s.r3);
        cmp("duty", pwm_duty_cycle, s.r4);
        cmp("duty_pending", duty_pending, s.pend);
        cmp("err_count", err_count, s.err);
        cmp("ovr_count", ovr_count, s.ovr);
      end
    end
    prev_ready = frame_ready;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [15:0] f, input logic p, input logic r);
    @(negedge clk);
    frame_valid    = v;
    frame          = f;
    pwm_period_end = p;
    rst            = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string tag);
    cmp({tag, "_ready"}, frame_ready, (cyc >= ready_at) ? 1 : 0);
    cmp({tag, "_out_lo"}, en_reg_out_7_0, m_reg[0]);
    cmp({tag, "_out_hi"}, en_reg_out_15_8, m_reg[1]);
    cmp({tag, "_pwm_lo"}, en_reg_pwm_7_0, m_reg[2]);
    cmp({tag, "_pwm_hi"}, en_reg_pwm_15_8, m_reg[3]);
    cmp({tag, "_duty"}, pwm_duty_cycle, m_reg[4]);
    cmp({tag, "_pend"}, duty_pending, m_pend);
    cmp({tag, "_err"}, err_count, m_err);
    cmp({tag, "_ovr"}, ovr_count, m_ovr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v, p, r;
    logic [15:0] f;

    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 0);
    mon_en = 1;
    check_now("reset");
    cmp("reset_all_zero", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, 32'h0);

    // Valid writes with explicit N+3 latency
    step(1, 16'h8055, 0, 0);
    idle(1); cmp("lat_n1", en_reg_out_7_0, 8'h00);
    idle(1); cmp("lat_n2", en_reg_out_7_0, 8'h00);
    idle(1); cmp("lat_n3", en_reg_out_7_0, 8'h55); cmp("lat_n3_ready", frame_ready, 1'b1);
    step(1, 16'h82F0, 0, 0);
    idle(3);
    cmp("wr_pwm_lo", en_reg_pwm_7_0, 8'hF0);
    cmp("wr_out_hi_untouched", en_reg_out_15_8, 8'h00);
    check_now("valid");

    // Rejected frames
    step(1, 16'h0012, 0, 0); idle(2);
    step(1, 16'h8A33, 0, 0); idle(2);
    cmp("reject_err", err_count, 8'd2);
    cmp("reject_out_lo", en_reg_out_7_0, 8'h55);
    check_now("reject");

    // Overrun
    step(1, 16'h8101, 0, 0);
    step(1, 16'h8102, 0, 0);
    idle(3);
    cmp("ovr_out_hi", en_reg_out_15_8, 8'h01);
    cmp("ovr_cnt", ovr_count, 8'd1);

    // Duty write
    step(1, 16'h8480, 0, 0);
    idle(3);
`ifdef SPI_REG_CTRL_DUTY_SHADOW_EN
    cmp("duty_shadow_pend", duty_pending, 1'b1);
    cmp("duty_shadow_live", pwm_duty_cycle, 8'h00);
    step(0, 16'h0, 1, 0);
    idle(1);
    cmp("duty_commit", pwm_duty_cycle, 8'h80);
    cmp("duty_commit_pend", duty_pending, 1'b0);
`else
    cmp("duty_direct", pwm_duty_cycle, 8'h80);
    cmp("duty_direct_pend", duty_pending, 1'b0);
`endif
    check_now("duty");

    // Commit collides with a duty APPLY
    step(1, 16'h8440, 0, 0); idle(3);
    step(1, 16'h8490, 0, 0);
    idle(1);
    step(0, 16'h0, 1, 0);
    idle(1);
`ifdef SPI_REG_CTRL_DUTY_SHADOW_EN
    cmp("collide_duty", pwm_duty_cycle, 8'h40);
    cmp("collide_pend", duty_pending, 1'b1);
    step(0, 16'h0, 1, 0);
    idle(1);
    cmp("collide_next", pwm_duty_cycle, 8'h90);
`else
    cmp("collide_direct", pwm_duty_cycle, 8'h90);
`endif
    check_now("collide");

    // Error counter saturation
    repeat (300) begin
      step(1, 16'(($urandom % 16'h8000)), 0, 0);
      idle(1);
    end
    idle(1);
    cmp("err_sat", err_count, 8'hFF);

    // Reset while the frame sits in DECODE
    step(1, 16'h8177, 0, 0);
    step(0, 16'h0, 0, 1);
    idle(1);
    check_now("rst_mid");
    cmp("rst_mid_err", err_count, 8'h00);
    cmp("rst_mid_ready", frame_ready, 1'b1);
    idle(3);
    cmp("rst_mid_never_applied", en_reg_out_15_8, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom % 100) < 35;
      f = {1'(($urandom % 4) != 0), 7'($urandom % 7), 8'($urandom)};
      p = ($urandom % 100) < 15;
      r = ($urandom % 1000) < 3;
      step(v, f, p, r);
    end
    idle(5);
    check_now("final");
    cmp("sb_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Register-write controller between the SPI frame receiver and the PWM/output-enable datapath.
- Accepts 16-bit SPI frames as a valid pulse, validates opcode and address, and sequences the write into the register bank that configures the output and PWM blocks.
- The duty-cycle register is double-buffered and commits only on a PWM period boundary.
- Keeps saturating error and overrun counters for debug readout.

Parameters:
- MAX_ADDR, 4: highest legal register address; frames addressed above it are rejected.
- ADDR_W, 7: address field width (frame bits 14:8).
- DATA_W, 8: data field width (frame bits 7:0).
- CNT_W, 8: width of the error and overrun counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_valid  in  1  one-cycle pulse; frame holds a complete SPI frame
- frame  in  16  bit15 = write(1)/read(0), bits 14:8 = address, bits 7:0 = data
- frame_ready  out  1  high only when the FSM is IDLE
- pwm_period_end  in  1  one-cycle strobe at PWM counter wrap; commit point for duty
- en_reg_out_7_0  out  8  register at address 0
- en_reg_out_15_8  out  8  register at address 1
- en_reg_pwm_7_0  out  8  register at address 2
- en_reg_pwm_15_8  out  8  register at address 3
- pwm_duty_cycle  out  8  live duty register at address 4
- duty_pending  out  1  shadow duty value written but not yet committed
- err_count  out  CNT_W  saturating count of rejected frames
- ovr_count  out  CNT_W  saturating count of frames dropped while busy

Behaviour:
- Clocking and reset:
  - Single clock domain; all state is updated on posedge clk.
  - rst is synchronous and active-high: when sampled high, every output register, the shadow duty register, the counters, duty_pending and the FSM clear to 0 / IDLE.
  - A reset asserted mid-transaction discards the held frame. No partial write occurs.
- FSM: IDLE -> DECODE -> APPLY -> IDLE.
  - IDLE: frame_ready=1. On frame_valid, latch frame into the hold register and go to DECODE.
  - DECODE: compute ok = frame[15] & (frame[14:8] <= MAX_ADDR). If ok, go to APPLY. Otherwise increment err_count and return to IDLE.
  - APPLY: write data to the addressed register, then go to IDLE.
    - Addresses 0-3 update their outputs directly.
    - Address 4 writes the shadow duty register and sets duty_pending.
- Latency:
  - Frame accepted in cycle N; register output shows the new value in cycle N+3.
  - frame_ready is high again in cycle N+3, so the controller sustains one frame per 3 cycles.
- Overrun:
  - frame_valid while frame_ready=0 drops that frame and increments ovr_count.
  - The frame in flight completes normally.
- Counters:
  - Saturate at all-ones and never wrap.
  - err_count and ovr_count increments in the same cycle each apply independently.
- Commit rule:
  - On pwm_period_end with duty_pending=1: pwm_duty_cycle <= shadow and duty_pending <= 0.
  - On pwm_period_end with duty_pending=0: no effect.
- Simultaneous events:
  - APPLY of address 4 in the same cycle as pwm_period_end: the commit uses the pre-write shadow value, the new value lands in the shadow, and duty_pending stays 1.
  - Repeated duty writes before a commit: the last write wins.
- Read frames (bit15=0) are rejected as errors. No readback path exists in this block.

Optional Feature:
- Macro: SPI_REG_CTRL_DUTY_SHADOW_EN
- Defined: double-buffered duty behaviour as above.
- Undefined:
  - Address 4 writes go straight to pwm_duty_cycle in APPLY, like addresses 0-3.
  - duty_pending is tied to 0 and pwm_period_end is ignored.

Decomposition:
- Shared package (spi_pkg):
  - FSM state enum (IDLE, DECODE, APPLY).
  - Register address constants ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4, and MAX_ADDR.
  - Frame field bit positions (WR_BIT=15, ADDR_MSB=14, ADDR_LSB=8).
- Sub-module: one natural sub-module, sat_counter (parameterised width, inc, rst), instantiated twice for err_count and ovr_count.

Test Plan:
- Valid writes: after reset, frame 0x8055 then 0x82F0 -> en_reg_out_7_0=0x55, en_reg_pwm_7_0=0xF0, each visible 3 cycles after accept; all other registers 0.
- Rejected frames: 0x0012 (read) and 0x8A33 (address 10) -> no register changes, err_count=2.
- Overrun: valid pulses in consecutive cycles with 0x8101 then 0x8102 -> en_reg_out_15_8=0x01, ovr_count=1.
- Duty shadow: 0x8480 -> duty_pending=1 and pwm_duty_cycle still 0; pulse pwm_period_end -> pwm_duty_cycle=0x80, duty_pending=0. Repeat with the macro undefined -> 0x80 visible at N+3 without the strobe.
- Commit collision: duty=0x40 pending; APPLY of 0x8490 coincides with pwm_period_end -> pwm_duty_cycle=0x40, duty_pending=1; next strobe -> 0x90.
- Saturation and reset: 300 bad frames -> err_count=0xFF; assert rst during DECODE of a valid frame -> all outputs 0, FSM IDLE, the frame is never applied.
